// File: rtl/ahb2apb_bridge.sv
// AHB-Lite slave to APB master bridge: one APB SETUP/ACCESS per AHB transfer, up to 16 slaves.
// Min 3 AHB wait states per transfer, plus one per PREADY-low ACCESS cycle.
// Decode misses and PSLVERR are answered with a two-cycle ERROR.
module ahb2apb_bridge #(
   parameter int AW    = 32,
   parameter int DW    = 32,
   parameter int P_NUM = 4,
   parameter int PA_W  = 12
) (
   input  logic                HCLK,
   input  logic                HRESETN,
   input  logic                HSEL,
   input  logic [AW-1:0]       HADDR,
   input  logic [1:0]          HTRANS,
   input  logic                HWRITE,
   input  logic [DW/8-1:0]     HWSTRB,
   input  logic [DW-1:0]       HWDATA,
   input  logic                HREADY_I,
   output logic                HREADY_O,
   output logic                HRESP,
   output logic [DW-1:0]       HRDATA,
   output logic [P_NUM-1:0]    PSEL,
   output logic                PENABLE,
   output logic [PA_W-1:0]     PADDR,
   output logic                PWRITE,
   output logic [DW-1:0]       PWDATA,
   output logic [DW/8-1:0]     PSTRB,
   input  logic [P_NUM*DW-1:0] PRDATA,
   input  logic [P_NUM-1:0]    PREADY,
   input  logic [P_NUM-1:0]    PSLVERR
);

   localparam int SW = DW/8;

   typedef enum logic [2:0] {
      S_IDLE, S_LATCH, S_SETUP, S_ACCESS, S_ERR1, S_ERR2
   } state_t;

   state_t             state_q;
   logic               hready_q;
   logic               hresp_q;
   logic [DW-1:0]      hrdata_q;
   logic [P_NUM-1:0]   psel_q;
   logic               penable_q;
   logic [PA_W-1:0]    paddr_q;
   logic               pwrite_q;
   logic [DW-1:0]      pwdata_q;
   logic [SW-1:0]      pstrb_q;
   logic [3:0]         idx_q;

   logic               accept;
   logic               miss;
   logic               sel_ready;
   logic               sel_err;
   logic [DW-1:0]      prdata_d;
   logic [P_NUM-1:0]   psel_d;
   logic [3:0]         hidx;

   assign hidx = HADDR[PA_W+3:PA_W];

   logic unused_bits;
   assign unused_bits = ^{HADDR[AW-1:PA_W+4], HTRANS[0]};

   // PSEL is one-hot during SETUP/ACCESS, so it doubles as the response mux select.
   always_comb begin
      accept    = HSEL && HTRANS[1] && HREADY_I &&
                  (state_q == S_IDLE || state_q == S_ERR2);
      miss      = ({1'b0, hidx} >= 5'(P_NUM));
      sel_ready = 1'b0;
      sel_err   = 1'b0;
      prdata_d  = '0;
      psel_d    = '0;
      for (int i = 0; i < P_NUM; i++) begin
         sel_ready = sel_ready | (psel_q[i] & PREADY[i]);
         sel_err   = sel_err   | (psel_q[i] & PSLVERR[i]);
         prdata_d  = prdata_d  | ({DW{psel_q[i]}} & PRDATA[i*DW +: DW]);
         psel_d[i] = (idx_q == 4'(i));
      end
   end

   always_ff @(posedge HCLK) begin
      if (!HRESETN) begin
         state_q   <= S_IDLE;
         hready_q  <= 1'b1;
         hresp_q   <= 1'b0;
         hrdata_q  <= '0;
         psel_q    <= '0;
         penable_q <= 1'b0;
         paddr_q   <= '0;
         pwrite_q  <= 1'b0;
         pwdata_q  <= '0;
         pstrb_q   <= '0;
         idx_q     <= '0;
      end else begin
         case (state_q)
            S_IDLE, S_ERR2: begin
               state_q  <= S_IDLE;
               hready_q <= 1'b1;
               hresp_q  <= 1'b0;
               if (accept) begin
                  hready_q <= 1'b0;
                  if (miss) begin
                     state_q <= S_ERR1;
                     hresp_q <= 1'b1;
                  end else begin
                     state_q  <= S_LATCH;
                     idx_q    <= hidx;
                     paddr_q  <= HADDR[PA_W-1:0];
                     pwrite_q <= HWRITE;
                  end
               end
            end
            S_LATCH: begin
               // HWDATA/HWSTRB belong to the data phase, valid only from this cycle on.
               pwdata_q <= HWDATA;
               pstrb_q  <= pwrite_q ? HWSTRB : '0;
               psel_q   <= psel_d;
               state_q  <= S_SETUP;
            end
            S_SETUP: begin
               penable_q <= 1'b1;
               state_q   <= S_ACCESS;
            end
            S_ACCESS: begin
               if (sel_ready) begin
                  psel_q    <= '0;
                  penable_q <= 1'b0;
                  if (sel_err) begin
                     state_q <= S_ERR1;
                     hresp_q <= 1'b1;
                  end else begin
                     state_q  <= S_IDLE;
                     hready_q <= 1'b1;
                     if (!pwrite_q) hrdata_q <= prdata_d;
                  end
               end
            end
            S_ERR1: begin
               state_q  <= S_ERR2;
               hready_q <= 1'b1;
               hresp_q  <= 1'b1;
            end
            default: begin
               state_q  <= S_IDLE;
               hready_q <= 1'b1;
               hresp_q  <= 1'b0;
            end
         endcase
      end
   end

   assign HREADY_O = hready_q;
   assign HRESP    = hresp_q;
   assign HRDATA   = hrdata_q;
   assign PSEL     = psel_q;
   assign PENABLE  = penable_q;
   assign PADDR    = paddr_q;
   assign PWRITE   = pwrite_q;
   assign PWDATA   = pwdata_q;
   assign PSTRB    = pstrb_q;

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// Bench for ahb2apb_bridge: directed cases plus random transfers against a memory-backed slave model.
module tb_ahb2apb_bridge;

   localparam int AW = 32, DW = 32, P_NUM = 4, PA_W = 12;

   logic                HCLK;
   logic                HRESETN;
   logic                HSEL;
   logic [AW-1:0]       HADDR;
   logic [1:0]          HTRANS;
   logic                HWRITE;
   logic [DW/8-1:0]     HWSTRB;
   logic [DW-1:0]       HWDATA;
   logic                HREADY_I;
   logic                HREADY_O;
   logic                HRESP;
   logic [DW-1:0]       HRDATA;
   logic [P_NUM-1:0]    PSEL;
   logic                PENABLE;
   logic [PA_W-1:0]     PADDR;
   logic                PWRITE;
   logic [DW-1:0]       PWDATA;
   logic [DW/8-1:0]     PSTRB;
   logic [P_NUM*DW-1:0] PRDATA;
   logic [P_NUM-1:0]    PREADY;
   logic [P_NUM-1:0]    PSLVERR;

   ahb2apb_bridge #(.AW(AW), .DW(DW), .P_NUM(P_NUM), .PA_W(PA_W)) dut (
      .HCLK(HCLK), .HRESETN(HRESETN), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
      .HWRITE(HWRITE), .HWSTRB(HWSTRB), .HWDATA(HWDATA), .HREADY_I(HREADY_I),
      .HREADY_O(HREADY_O), .HRESP(HRESP), .HRDATA(HRDATA), .PSEL(PSEL),
      .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
      .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
   );

   initial begin
      HCLK = 1'b0;
      forever #5 HCLK = ~HCLK;
   end

   int          n_chk  = 0;
   int          n_fail = 0;
   logic [31:0] mem [4][1024];
   logic [31:0] exp_hrdata;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic addr_phase(input int idx, input logic [11:0] off, input logic wr);
      HSEL   = 1'b1;
      HTRANS = 2'b10;
      HADDR  = {16'h0, 4'(idx), off};
      HWRITE = wr;
   endtask

   // Runs from the first data-phase cycle to the completion cycle (HREADY_O=1),
   // acting as the APB slaves and checking the result against the memory model.
   task automatic data_phase(input int idx, input logic [11:0] off, input logic wr,
                             input logic [31:0] wdata, input logic [3:0] strb,
                             input int stall, input logic err_in);
      logic       miss, err, done, last_resp;
      logic [3:0] exp_sel;
      int         waits, acc, psel_cyc, c, exp_waits;
      @(negedge HCLK);
      HSEL = 1'b0; HTRANS = 2'b00; HADDR = $urandom; HWRITE = 1'($urandom);
      HWDATA = wdata; HWSTRB = strb;
      miss      = (idx >= P_NUM);
      err       = err_in && !miss;
      exp_sel   = miss ? 4'b0 : 4'(1 << idx);
      exp_waits = miss ? 1 : (3 + stall + (err ? 1 : 0));
      waits = 0; acc = 0; psel_cyc = 0; c = 0; done = 1'b0; last_resp = 1'b0;
      while (!done && c < 60) begin
         c++;
         PREADY  = 4'($urandom);
         PSLVERR = 4'($urandom);
         PRDATA  = {$urandom(), $urandom(), $urandom(), $urandom()};
         if (HREADY_O === 1'b1) begin
            done = 1'b1;
         end else begin
            if (waits == 0) chk("latch_psel_low", PSEL, 0);
            waits++;
            last_resp = HRESP;
            if (PSEL !== 4'b0) begin
               psel_cyc++;
               chk("psel", PSEL, exp_sel);
               chk("penable", PENABLE, (psel_cyc > 1));
               chk("paddr", PADDR, off);
               chk("pwrite", PWRITE, wr);
               chk("pstrb", PSTRB, wr ? strb : 4'b0);
               if (wr) chk("pwdata", PWDATA, wdata);
            end
            if (!miss && PSEL[idx[1:0]] === 1'b1 && PENABLE === 1'b1) begin
               PREADY[idx[1:0]]  = (acc >= stall);
               PSLVERR[idx[1:0]] = err && (acc >= stall);
               PRDATA[idx*32 +: 32] = mem[idx[1:0]][off[11:2]];
               acc++;
            end
            @(negedge HCLK);
         end
      end
      chk("complete", done, 1);
      chk("wait_states", waits, exp_waits);
      chk("hresp_final", HRESP, miss || err);
      chk("hresp_last_wait", last_resp, miss || err);
      chk("psel_cycles", psel_cyc, miss ? 0 : 2 + stall);
      if (!miss && !err) begin
         if (wr) begin
            for (int b = 0; b < 4; b++)
               if (strb[b]) mem[idx[1:0]][off[11:2]][b*8 +: 8] = wdata[b*8 +: 8];
         end else begin
            exp_hrdata = mem[idx[1:0]][off[11:2]];
         end
      end
      chk("hrdata", HRDATA, exp_hrdata);
   endtask

   initial begin
      int          idx, stall, c;
      logic [11:0] off;
      logic        wr, err;
      logic [31:0] wdata;
      logic [3:0]  strb;

      HRESETN = 1'b0; HSEL = 1'b0; HTRANS = 2'b00; HADDR = '0; HWRITE = 1'b0;
      HWSTRB = '0; HWDATA = '0; HREADY_I = 1'b1; PRDATA = '0; PREADY = '0; PSLVERR = '0;
      exp_hrdata = '0;
      for (int s = 0; s < 4; s++)
         for (int w = 0; w < 1024; w++) mem[s][w] = $urandom;

      repeat (3) @(negedge HCLK);
      chk("rst_hready", HREADY_O, 1);
      chk("rst_hresp", HRESP, 0);
      chk("rst_hrdata", HRDATA, 0);
      chk("rst_psel", PSEL, 0);
      chk("rst_penable", PENABLE, 0);
      chk("rst_paddr", PADDR, 0);
      chk("rst_pwrite", PWRITE, 0);
      chk("rst_pwdata", PWDATA, 0);
      chk("rst_pstrb", PSTRB, 0);
      HRESETN = 1'b1;
      @(negedge HCLK);

      // Write 0xDEADBEEF to slave 1 offset 0x010.
      addr_phase(1, 12'h010, 1'b1);
      data_phase(1, 12'h010, 1'b1, 32'hDEADBEEF, 4'hF, 0, 1'b0);

      // Read slave 3 offset 0x004 with two stalled ACCESS cycles.
      mem[3][1] = 32'h12345678;
      addr_phase(3, 12'h004, 1'b0);
      data_phase(3, 12'h004, 1'b0, $urandom, 4'($urandom), 2, 1'b0);
      chk("read_value", HRDATA, 32'h12345678);

      // Decode miss on slave index 5, then an OKAY idle cycle.
      addr_phase(5, 12'h000, 1'b0);
      data_phase(5, 12'h000, 1'b0, $urandom, 4'($urandom), 0, 1'b0);
      @(negedge HCLK);
      chk("miss_idle_hready", HREADY_O, 1);
      chk("miss_idle_hresp", HRESP, 0);
      chk("miss_idle_psel", PSEL, 0);

      // PSLVERR on a write to slave 2.
      addr_phase(2, 12'h008, 1'b1);
      data_phase(2, 12'h008, 1'b1, 32'hCAFEF00D, 4'hF, 1, 1'b1);

      // Back-to-back write then read of the same location.
      addr_phase(0, 12'h00C, 1'b1);
      data_phase(0, 12'h00C, 1'b1, 32'hA5A55A5A, 4'b0101, 1, 1'b0);
      addr_phase(0, 12'h00C, 1'b0);
      data_phase(0, 12'h00C, 1'b0, $urandom, 4'($urandom), 0, 1'b0);

      // BUSY transfers and transfers with HREADY_I low are ignored.
      HSEL = 1'b1; HTRANS = 2'b01; HADDR = 32'h0000_1000; HWRITE = 1'b1;
      @(negedge HCLK);
      chk("busy_hready", HREADY_O, 1);
      HTRANS = 2'b10; HREADY_I = 1'b0;
      @(negedge HCLK);
      chk("nordy_hready", HREADY_O, 1);
      HSEL = 1'b0; HTRANS = 2'b00; HREADY_I = 1'b1;
      @(negedge HCLK);
      chk("nordy_psel", PSEL, 0);
      chk("nordy_hready2", HREADY_O, 1);

      // Reset asserted in the middle of ACCESS.
      addr_phase(1, 12'h020, 1'b1);
      @(negedge HCLK);
      HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'h0BAD0BAD; HWSTRB = 4'hF;
      PREADY = '0; PSLVERR = '0;
      c = 0;
      while (PENABLE !== 1'b1 && c < 10) begin
         @(negedge HCLK);
         c++;
      end
      chk("rst_reached_access", PENABLE, 1);
      HRESETN = 1'b0;
      @(negedge HCLK);
      chk("midrst_psel", PSEL, 0);
      chk("midrst_penable", PENABLE, 0);
      chk("midrst_hready", HREADY_O, 1);
      chk("midrst_hresp", HRESP, 0);
      chk("midrst_hrdata", HRDATA, 0);
      exp_hrdata = '0;
      HRESETN = 1'b1;
      @(negedge HCLK);
      addr_phase(1, 12'h020, 1'b0);
      data_phase(1, 12'h020, 1'b0, $urandom, 4'($urandom), 1, 1'b0);

      // Random transfers, some back-to-back, some after ignored idle cycles.
      repeat (60) begin
         idx   = $urandom_range(0, 5);
         off   = {6'b0, 4'($urandom), 2'b00};
         wr    = 1'($urandom);
         wdata = $urandom;
         strb  = 4'($urandom);
         stall = $urandom_range(0, 3);
         err   = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 1) == 1) begin
            HSEL = 1'($urandom); HTRANS = 2'($urandom_range(0, 1)); HADDR = $urandom;
            @(negedge HCLK);
            chk("idle_hready", HREADY_O, 1);
            chk("idle_psel", PSEL, 0);
         end
         addr_phase(idx, off, wr);
         data_phase(idx, off, wr, wdata, strb, stall, err);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
